// File: rtl/biquad_coef_loader_if.sv
// Coefficient ROM read bus: the loader masters address/strobe, the ROM
// answers with data one cycle after each strobe.
interface biquad_coef_loader_if #(
    parameter int AW = 12,
    parameter int DW = 32
) ();
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    modport master (
        output rom_rd_en,
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_rd_en,
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/biquad_coef_loader.sv
// Fetches a full biquad cascade coefficient set from ROM into shadow
// registers and commits it to the active outputs on a sample tick.
module biquad_coef_loader #(
    parameter int NUM_STAGES = 6,
    parameter int COEF_W     = 32,
    parameter int FRAC       = 30,
    parameter int TYPE_W     = 2,
    parameter int IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic                         update_req,
    input  logic [TYPE_W-1:0]            filt_type,
    input  logic [IDX_W-1:0]             cutoff_idx,
    biquad_coef_loader_if.master         rom,
    output logic [NUM_STAGES*COEF_W-1:0] coef_b0,
    output logic [NUM_STAGES*COEF_W-1:0] coef_b1,
    output logic [NUM_STAGES*COEF_W-1:0] coef_b2,
    output logic [NUM_STAGES*COEF_W-1:0] coef_a1,
    output logic [NUM_STAGES*COEF_W-1:0] coef_a2,
    output logic                         coef_valid,
    output logic                         busy
);

    localparam int AW = TYPE_W + IDX_W + 6;
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [COEF_W-1:0] UNITY =
        {{(COEF_W-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_TICK
    } state_e;

    state_e              state_q;
    logic [TYPE_W-1:0]   req_type_q;
    logic [IDX_W-1:0]    req_idx_q;
    logic [TYPE_W-1:0]   cur_type_q;
    logic [IDX_W-1:0]    cur_idx_q;
    logic                pend_q;
    logic [2:0]          stage_q;
    logic [2:0]          sel_q;
    logic                wr_en_q;
    logic [2:0]          wr_stage_q;
    logic [2:0]          wr_sel_q;
    logic                rd_en_q;
    logic [AW-1:0]       addr_q;
    logic                valid_q;
    logic                busy_q;
    logic [COEF_W-1:0]   shd_q [NUM_STAGES][5];
    logic [COEF_W-1:0]   act_q [NUM_STAGES][5];

    // A request presented this cycle always wins over the held one.
    logic [TYPE_W-1:0]   nxt_type_d;
    logic [IDX_W-1:0]    nxt_idx_d;

    always_comb begin
        nxt_type_d = update_req ? filt_type : req_type_q;
        nxt_idx_d  = update_req ? cutoff_idx : req_idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_type_q <= '0;
            req_idx_q  <= '0;
            cur_type_q <= '0;
            cur_idx_q  <= '0;
            pend_q     <= 1'b0;
            stage_q    <= '0;
            sel_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_stage_q <= '0;
            wr_sel_q   <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                for (int k = 0; k < 5; k++) begin
                    shd_q[s][k] <= (k == 0) ? UNITY : '0;
                    act_q[s][k] <= (k == 0) ? UNITY : '0;
                end
            end
        end else begin
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
            if (wr_en_q) begin
                shd_q[wr_stage_q][wr_sel_q] <= rom.rom_data;
            end
            if (update_req) begin
                req_type_q <= filt_type;
                req_idx_q  <= cutoff_idx;
            end

            unique case (state_q)
                IDLE: begin
                    if (update_req) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        stage_q    <= '0;
                        sel_q      <= '0;
                        cur_type_q <= nxt_type_d;
                        cur_idx_q  <= nxt_idx_d;
                        addr_q     <= {nxt_type_d, nxt_idx_d, 6'd0};
                    end
                end
                FETCH: begin
                    if (update_req) begin
                        pend_q <= 1'b1;
                    end
                    // Data returns next cycle; remember where it belongs.
                    wr_en_q    <= 1'b1;
                    wr_stage_q <= stage_q;
                    wr_sel_q   <= sel_q;
                    if (sel_q == 3'd4) begin
                        sel_q <= '0;
                        if (stage_q == LAST_STAGE) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            stage_q <= stage_q + 3'd1;
                            addr_q  <= {cur_type_q, cur_idx_q,
                                        stage_q + 3'd1, 3'd0};
                        end
                    end else begin
                        sel_q  <= sel_q + 3'd1;
                        addr_q <= {cur_type_q, cur_idx_q,
                                   stage_q, sel_q + 3'd1};
                    end
                end
                DRAIN: begin
                    if (update_req) begin
                        pend_q <= 1'b1;
                    end
                    state_q <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (sample_tick) begin
                        act_q   <= shd_q;
                        valid_q <= 1'b1;
                        if (pend_q || update_req) begin
                            pend_q     <= 1'b0;
                            state_q    <= FETCH;
                            rd_en_q    <= 1'b1;
                            stage_q    <= '0;
                            sel_q      <= '0;
                            cur_type_q <= nxt_type_d;
                            cur_idx_q  <= nxt_idx_d;
                            addr_q     <= {nxt_type_d, nxt_idx_d, 6'd0};
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (update_req) begin
                        pend_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rom.rom_rd_en = rd_en_q;
    assign rom.rom_addr  = addr_q;
    assign coef_valid    = valid_q;
    assign busy          = busy_q;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_out
        assign coef_b0[s*COEF_W +: COEF_W] = act_q[s][0];
        assign coef_b1[s*COEF_W +: COEF_W] = act_q[s][1];
        assign coef_b2[s*COEF_W +: COEF_W] = act_q[s][2];
        assign coef_a1[s*COEF_W +: COEF_W] = act_q[s][3];
        assign coef_a2[s*COEF_W +: COEF_W] = act_q[s][4];
    end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed bench for biquad_coef_loader: the ROM echoes its address as
// data so every committed coefficient identifies its own fetch.
module tb_biquad_coef_loader;

    localparam int NS  = 6;
    localparam int CW  = 32;
    localparam int TW  = 2;
    localparam int IW  = 4;
    localparam int AW  = TW + IW + 6;
    localparam int TOT = 5 * NS * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic          update_req;
    logic [TW-1:0] filt_type;
    logic [IW-1:0] cutoff_idx;
    logic [NS*CW-1:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
    logic          coef_valid;
    logic          busy;
    logic [TOT-1:0] act_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biquad_coef_loader_if #(.AW(AW), .DW(CW)) rom_if ();

    always_ff @(posedge clk) begin
        rom_if.rom_data <= rom_if.rom_rd_en ? 32'(rom_if.rom_addr)
                                            : 32'hDEAD_BEEF;
    end

    biquad_coef_loader #(
        .NUM_STAGES(NS), .COEF_W(CW), .FRAC(30),
        .TYPE_W(TW), .IDX_W(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_tick(sample_tick),
        .update_req(update_req),
        .filt_type(filt_type),
        .cutoff_idx(cutoff_idx),
        .rom(rom_if),
        .coef_b0(coef_b0),
        .coef_b1(coef_b1),
        .coef_b2(coef_b2),
        .coef_a1(coef_a1),
        .coef_a2(coef_a2),
        .coef_valid(coef_valid),
        .busy(busy)
    );

    assign act_all = {coef_a2, coef_a1, coef_b2, coef_b1, coef_b0};

    typedef struct {
        logic [1:0]  t;
        logic [3:0]  i;
        int          s;
        int          k;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [CW-1:0] model(input bit rst,
            input logic [1:0] t, input logic [3:0] i,
            input int s, input int k);
        if (rst) return (k == 0) ? 32'h4000_0000 : 32'h0;
        return 32'({t, i, 3'(s), 3'(k)});
    endfunction

    function automatic logic [CW-1:0] coef_at(input int s, input int k);
        return act_all[(k*NS+s)*CW +: CW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input bit rst,
                           input logic [1:0] t, input logic [3:0] i);
        bit bad;
        bad = 1'b0;
        checks++;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < 5; k++) begin
                if (!bad && coef_at(s, k) !== model(rst, t, i, s, k)) begin
                    bad = 1'b1;
                    errors++;
                    $display("FAIL %s: stage %0d sel %0d got %h expected %h",
                             nm, s, k, coef_at(s, k), model(rst, t, i, s, k));
                end
            end
        end
    endtask

    task automatic load_fast(input logic [1:0] t, input logic [3:0] i,
                             output int lat);
        sample_tick = 1'b1;
        filt_type   = t;
        cutoff_idx  = i;
        update_req  = 1'b1;
        step();
        update_req = 1'b0;
        lat = 1;
        while (!coef_valid && lat < 60) begin
            step();
            lat++;
        end
        sample_tick = 1'b0;
    endtask

    vec_t tbl[5];
    int   lat;
    int   vcnt;
    int   drops;

    initial begin
        tbl[0] = '{2'd0, 4'd0,  0, 0, 32'h0000_0000};
        tbl[1] = '{2'd3, 4'd15, 5, 4, 32'h0000_0FEC};
        tbl[2] = '{2'd1, 4'd9,  2, 3, 32'h0000_0653};
        tbl[3] = '{2'd2, 4'd5,  4, 1, 32'h0000_0961};
        tbl[4] = '{2'd0, 4'd10, 1, 2, 32'h0000_028A};

        reset = 1'b1;
        sample_tick = 1'b0;
        update_req = 1'b0;
        filt_type = '0;
        cutoff_idx = '0;
        repeat (3) step();
        chk_all("reset_coefs", 1'b1, 2'd0, 4'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(coef_valid), 64'd0);
        chk("reset_rden", 64'(rom_if.rom_rd_en), 64'd0);
        chk("reset_addr", 64'(rom_if.rom_addr), 64'd0);
        reset = 1'b0;
        step();

        // Slow tick: full fetch order, then commit 50 cycles later.
        filt_type = 2'd2;
        cutoff_idx = 4'd5;
        update_req = 1'b1;
        chk("idle_rden", 64'(rom_if.rom_rd_en), 64'd0);
        step();
        update_req = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c <= 30) begin
                chk("fetch_rden", 64'(rom_if.rom_rd_en), 64'd1);
                chk("fetch_addr", 64'(rom_if.rom_addr),
                    64'({2'd2, 4'd5, 3'((c-1)/5), 3'((c-1)%5)}));
            end else begin
                chk("post_fetch_rden", 64'(rom_if.rom_rd_en), 64'd0);
            end
            chk("load_busy", 64'(busy), 64'd1);
            chk("load_valid_low", 64'(coef_valid), 64'd0);
            chk_all("hold_old", 1'b1, 2'd0, 4'd0);
            sample_tick = (c == 50);
            step();
        end
        sample_tick = 1'b0;
        chk("commit_valid", 64'(coef_valid), 64'd1);
        chk("commit_busy", 64'(busy), 64'd0);
        chk_all("commit_25", 1'b0, 2'd2, 4'd5);
        step();
        chk("valid_one_shot", 64'(coef_valid), 64'd0);

        // Tick held high: commit visible 32 cycles after cycle 1.
        sample_tick = 1'b1;
        filt_type = 2'd1;
        cutoff_idx = 4'd3;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            chk("no_early_valid", 64'(coef_valid), 64'd0);
            chk_all("no_early_commit", 1'b0, 2'd2, 4'd5);
            step();
        end
        chk("tick_hi_valid", 64'(coef_valid), 64'd1);
        chk("tick_hi_busy", 64'(busy), 64'd0);
        chk_all("tick_hi_coefs", 1'b0, 2'd1, 4'd3);
        sample_tick = 1'b0;
        step();

        for (int n = 0; n < 5; n++) begin
            load_fast(tbl[n].t, tbl[n].i, lat);
            chk("tbl_latency", 64'(lat), 64'd33);
            chk("tbl_probe", 64'(coef_at(tbl[n].s, tbl[n].k)),
                64'(tbl[n].exp));
            chk_all("tbl_all", 1'b0, tbl[n].t, tbl[n].i);
            step();
        end

        // Requests during fetch: latest wins, refetch with no busy gap.
        filt_type = 2'd2;
        cutoff_idx = 4'd5;
        update_req = 1'b1;
        step();
        vcnt = 0;
        drops = 0;
        for (int c = 1; c <= 85; c++) begin
            update_req = (c == 5) || (c == 10);
            if (c == 5) cutoff_idx = 4'd7;
            if (c == 10) cutoff_idx = 4'd9;
            sample_tick = (c == 40) || (c == 80);
            if (coef_valid) vcnt++;
            if (c <= 80 && !busy) drops++;
            if (c == 41) begin
                chk("pend_valid", 64'(coef_valid), 64'd1);
                chk("pend_busy", 64'(busy), 64'd1);
                chk_all("pend_first", 1'b0, 2'd2, 4'd5);
                chk("pend_rden", 64'(rom_if.rom_rd_en), 64'd1);
                chk("pend_addr", 64'(rom_if.rom_addr),
                    64'({2'd2, 4'd9, 6'd0}));
            end
            if (c == 70) chk_all("pend_hold", 1'b0, 2'd2, 4'd5);
            if (c == 81) begin
                chk_all("pend_second", 1'b0, 2'd2, 4'd9);
                chk("pend_busy_end", 64'(busy), 64'd0);
            end
            step();
        end
        update_req = 1'b0;
        sample_tick = 1'b0;
        chk("pend_valid_pulses", 64'(vcnt), 64'd2);
        chk("pend_busy_gaps", 64'(drops), 64'd0);

        // Reset in stage 3 of a fetch.
        filt_type = 2'd1;
        cutoff_idx = 4'd1;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        repeat (16) step();
        chk("mid_addr", 64'(rom_if.rom_addr),
            64'({2'd1, 4'd1, 3'd3, 3'd1}));
        reset = 1'b1;
        step();
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_rden", 64'(rom_if.rom_rd_en), 64'd0);
        chk("rst_mid_addr", 64'(rom_if.rom_addr), 64'd0);
        chk("rst_mid_valid", 64'(coef_valid), 64'd0);
        chk_all("rst_mid_coefs", 1'b1, 2'd0, 4'd0);
        reset = 1'b0;
        step();
        load_fast(2'd0, 4'd15, lat);
        chk("post_rst_latency", 64'(lat), 64'd33);
        chk_all("post_rst_load", 1'b0, 2'd0, 4'd15);
        step();

        // Request arriving on the commit edge itself.
        filt_type = 2'd1;
        cutoff_idx = 4'd2;
        update_req = 1'b1;
        step();
        for (int c = 1; c <= 85; c++) begin
            update_req = (c == 40);
            if (c == 40) begin
                filt_type = 2'd3;
                cutoff_idx = 4'd10;
            end
            if (c == 41) begin
                filt_type = 2'd0;
                cutoff_idx = 4'd0;
            end
            sample_tick = (c == 40) || (c == 80);
            if (c == 41) begin
                chk("edge_valid", 64'(coef_valid), 64'd1);
                chk("edge_busy", 64'(busy), 64'd1);
                chk("edge_rden", 64'(rom_if.rom_rd_en), 64'd1);
                chk("edge_addr0", 64'(rom_if.rom_addr),
                    64'({2'd3, 4'd10, 6'd0}));
                chk_all("edge_first", 1'b0, 2'd1, 4'd2);
            end
            if (c == 42) begin
                chk("edge_addr1", 64'(rom_if.rom_addr),
                    64'({2'd3, 4'd10, 3'd0, 3'd1}));
            end
            if (c == 81) begin
                chk("edge_valid2", 64'(coef_valid), 64'd1);
                chk("edge_busy2", 64'(busy), 64'd0);
                chk_all("edge_second", 1'b0, 2'd3, 4'd10);
            end
            step();
        end
        update_req = 1'b0;
        sample_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_coef_loader.md
Name: biquad_coef_loader

Overview:
- Writer side of the biquad coefficient interface. Drives the A1/A2/B0/B1/B2 inputs of a NUM_STAGES-deep biquad cascade, such as the 12th-order high-pass chain.
- On an update request, fetches 5 coefficients per stage from a synchronous coefficient ROM into shadow registers.
- Commits all stages atomically on the next audio sample tick, so the cascade never runs with mixed old/new coefficients.

Parameters:
- NUM_STAGES, 6, number of biquad stages driven (1..8).
- COEF_W, 32, coefficient width, signed two's complement.
- FRAC, 30, fractional bits of coefficient format (Q(COEF_W-FRAC).FRAC).
- TYPE_W, 2, filter-type select width.
- IDX_W, 4, cutoff-index select width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe, one per audio sample.
- update_req  in  1  one-cycle request to load a new coefficient set.
- filt_type  in  TYPE_W  filter type, captured when update_req=1.
- cutoff_idx  in  IDX_W  cutoff index, captured when update_req=1.
- rom_rd_en  out  1  ROM read strobe.
- rom_addr  out  TYPE_W+IDX_W+6  = {type, idx, stage[2:0], sel[2:0]}.
- rom_data  in  COEF_W  ROM read data, valid exactly 1 cycle after rom_rd_en.
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  out  NUM_STAGES*COEF_W each  active coefficients, stage s at bits [s*COEF_W +: COEF_W].
- coef_valid  out  1  one-cycle pulse the cycle after a commit.
- busy  out  1  high from request accept until commit.

Behaviour:
- Reset values, whole block: state IDLE; busy=0, rom_rd_en=0, rom_addr=0, coef_valid=0, pending flag cleared.
- Reset values, per stage: active and shadow coef_b0 = 1<<FRAC (unity pass-through); b1, b2, a1, a2 = 0.
- Reset mid-operation aborts any fetch and discards shadow contents.
- sel order is 0=B0, 1=B1, 2=B2, 3=A1, 4=A2. sel 5..7 are never issued.
- IDLE:
  - update_req=1 captures filt_type/cutoff_idx into request registers.
  - Next state FETCH; busy=1 from the next cycle.
- FETCH:
  - Issues one read per cycle, stage-major: stage 0 sel 0..4, then stage 1, and so on.
  - Takes exactly 5*NUM_STAGES cycles with rom_rd_en continuously high.
  - rom_data is written into shadow[stage][sel] the cycle after its read, using a one-cycle delayed copy of stage/sel.
  - After the last read, go to DRAIN.
- DRAIN: one cycle, rom_rd_en=0, last shadow write occurs. Then WAIT_TICK.
- WAIT_TICK:
  - On the clock edge where sample_tick=1, all shadow registers copy to active in one cycle.
  - coef_valid=1 on the following cycle only; busy drops on that same following cycle.
  - Then IDLE.
- Timing:
  - A sample_tick during FETCH or DRAIN is ignored.
  - Minimum request-to-active latency = 5*NUM_STAGES+2 cycles plus the wait for a tick.
- update_req while busy:
  - Sets the pending flag and overwrites the request registers (latest request wins; one-deep).
  - The in-flight fetch keeps using the addresses it latched at its own start.
- After commit with pending set:
  - Clear pending; enter FETCH directly on the cycle after the commit, using the latest captured values.
  - busy stays high continuously.
- update_req on the same cycle as the commit edge sets pending.
- Active outputs change only at a commit edge or at reset; they never change during FETCH/DRAIN/WAIT_TICK.
- No arithmetic on coefficients: values are passed bit-exact, no saturation or rescaling.

Test Plan:
- Reset held 3 cycles -> every stage b0=0x40000000, others 0; busy=0, coef_valid=0, rom_rd_en=0.
- ROM model returns rom_data=rom_addr; update_req with type=2, idx=5; tick 50 cycles later:
  - rom_rd_en high exactly 30 consecutive cycles, addresses in stage-major order.
  - Active values unchanged until the tick edge.
  - Afterwards, stage s sel k = {2,5,s,k}; coef_valid pulses once.
- sample_tick held high continuously -> commit occurs exactly 32 cycles after the cycle following update_req; no early commit during FETCH/DRAIN.
- Second and third update_req (idx=7, then idx=9) during FETCH:
  - First set commits with idx=5.
  - Immediate refetch uses idx=9 only; busy never drops between the two loads; two coef_valid pulses total.
- reset asserted mid-FETCH (stage 3) -> next cycle state IDLE, all outputs at reset values; a fresh update_req then completes a normal load.
- update_req on the commit edge -> pending honoured: new FETCH starts the cycle after the commit, and the latched values are those presented with that request.
